// File: rtl/ram8_bank.sv
// Eight-word leaf register bank: one-hot decoded write port, two registered
// read ports with write-first bypass, and a sequential clear-all sweep.
module ram8_bank #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic [2:0]       addr_a,
  input  logic [2:0]       addr_b,
  input  logic             clear,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             busy,
  output logic             clear_done,
  output logic             o_dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [WIDTH-1:0] r_mem [8];

  logic             w_write_accept;
  logic [7:0]       w_load_en;
  logic             w_sweeping;

  // busy is the registered status seen by the writer, so a load arriving on
  // the same edge that starts a sweep is still accepted.
  assign w_write_accept = load & ~busy;
  assign w_load_en      = w_write_accept ? (8'b0000_0001 << address) : 8'b0;
  assign w_sweeping     = (r_state == CLEAR);
  assign o_dbg_state    = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) r_mem[k] <= '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (w_sweeping && (r_idx == 3'(k))) begin
          r_mem[k] <= '0;
        end else if (w_load_en[k]) begin
          r_mem[k] <= in;
        end
      end
    end
  end

  // Bypass covers host writes only; sweep zeroing is seen one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a <= '0;
      out_b <= '0;
    end else begin
      out_a <= (w_write_accept && (addr_a == address)) ? in : r_mem[addr_a];
      out_b <= (w_write_accept && (addr_b == address)) ? in : r_mem[addr_b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= 3'd0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clear) begin
            r_state <= CLEAR;
            r_idx   <= 3'd0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            r_state    <= IDLE;
            r_idx      <= 3'd0;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= 3'd0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram8_bank.sv
// Self-checking bench for ram8_bank: vector table, directed sweep sequences
// and random traffic against a word-array reference model.
module tb_ram8_bank;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] d_in;
  logic             d_load;
  logic [2:0]       d_address;
  logic [2:0]       d_addr_a;
  logic [2:0]       d_addr_b;
  logic             d_clear;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             busy;
  logic             clear_done;
  logic             dbg_state;

  ram8_bank #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (d_in),
    .load       (d_load),
    .address    (d_address),
    .addr_a     (d_addr_a),
    .addr_b     (d_addr_b),
    .clear      (d_clear),
    .out_a      (out_a),
    .out_b      (out_b),
    .busy       (busy),
    .clear_done (clear_done),
    .o_dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain word array plus count of words still to sweep.
  logic [WIDTH-1:0] m_mem [8];
  logic [WIDTH-1:0] m_a, m_b;
  logic             m_busy, m_done;
  int               m_left;

  typedef struct {
    logic             load;
    logic [2:0]       address;
    logic [WIDTH-1:0] din;
    logic [2:0]       addr_a;
    logic [2:0]       addr_b;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 8; k++) m_mem[k] = '0;
    m_a = '0; m_b = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
  endtask

  task automatic model_step();
    logic accept;
    accept = d_load && !m_busy;
    m_a = (accept && d_addr_a == d_address) ? d_in : m_mem[d_addr_a];
    m_b = (accept && d_addr_b == d_address) ? d_in : m_mem[d_addr_b];
    if (accept) m_mem[d_address] = d_in;
    m_done = 1'b0;
    if (m_busy) begin
      m_mem[8 - m_left] = '0;
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (d_clear) begin
      m_busy = 1'b1;
      m_left = 8;
    end
  endtask

  task automatic check_model();
    chk("out_a", out_a, m_a);
    chk("out_b", out_b, m_b);
    chk("busy", 16'(busy), 16'(m_busy));
    chk("clear_done", 16'(clear_done), 16'(m_done));
    chk("dbg_state", 16'(dbg_state), 16'(m_busy));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    d_load = 1'b0; d_clear = 1'b0; d_in = '0; d_address = 3'd0;
  endtask

  // Starts a sweep and measures how many cycles busy stays high.
  task automatic sweep_run(input bit start_load2, input bit load6, input bit reclear,
                           output int n);
    d_clear = 1'b1;
    if (start_load2) begin
      d_load = 1'b1; d_address = 3'd2; d_in = 16'h00AA;
    end
    cycle();
    idle_inputs();
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      d_load = (load6 && n == 2);
      d_address = 3'd6; d_in = 16'h1234;
      d_clear = (reclear && n == 4);
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    int n;
    m_reset();
    rst_n = 1'b0;
    idle_inputs();
    d_addr_a = 3'd0; d_addr_b = 3'd0;
    #12;
    chk("rst_out_a", out_a, '0);
    chk("rst_out_b", out_b, '0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(clear_done), 16'd0);
    rst_n = 1'b1;

    // Reset readback across all words.
    for (int k = 0; k < 8; k++) begin
      d_addr_a = 3'(k);
      cycle();
      chk("rst_read", out_a, '0);
    end

    // Vector table: writes, cross reads, bypass.
    for (int k = 0; k < 8; k++) begin
      vecs[k]   = '{1'b1, 3'(k), 16'h1000 + 16'(k), 3'(k), 3'd0, 16'h1000 + 16'(k), 16'h1000};
      vecs[8+k] = '{1'b0, 3'd0, 16'h0, 3'(k), 3'(7-k), 16'h1000 + 16'(k), 16'h1007 - 16'(k)};
    end
    vecs[16] = '{1'b1, 3'd4, 16'h0004, 3'd0, 3'd7, 16'h1000, 16'h1007};
    vecs[17] = '{1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd4, 16'hBEEF, 16'h0004};
    vecs[18] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF};
    for (int i = 0; i < 19; i++) begin
      d_load = vecs[i].load; d_address = vecs[i].address; d_in = vecs[i].din;
      d_addr_a = vecs[i].addr_a; d_addr_b = vecs[i].addr_b;
      cycle();
      chk("vec_a", out_a, vecs[i].exp_a);
      chk("vec_b", out_b, vecs[i].exp_b);
    end
    idle_inputs();

    // Fill with FFFF, sweep while watching word 5.
    for (int k = 0; k < 8; k++) begin
      d_load = 1'b1; d_address = 3'(k); d_in = 16'hFFFF;
      cycle();
    end
    idle_inputs();
    d_addr_a = 3'd5; d_addr_b = 3'd7;
    sweep_run(1'b0, 1'b0, 1'b0, n);
    chk("busy_len", 16'(n), 16'd8);
    chk("done_at_fall", 16'(clear_done), 16'd1);
    cycle();
    chk("done_one_cycle", 16'(clear_done), 16'd0);
    for (int k = 0; k < 8; k++) begin
      d_addr_a = 3'(k);
      cycle();
      chk("swept_zero", out_a, '0);
    end

    // Load at sweep start, load during busy, second clear during busy.
    d_load = 1'b1; d_address = 3'd5; d_in = 16'h5555;
    cycle();
    idle_inputs();
    d_addr_a = 3'd2; d_addr_b = 3'd6;
    sweep_run(1'b1, 1'b1, 1'b1, n);
    chk("busy_len2", 16'(n), 16'd8);
    cycle();
    chk("word2_zero", out_a, '0);
    chk("word6_zero", out_b, '0);

    // Back-to-back: clear while clear_done high restarts.
    d_clear = 1'b1;
    cycle();
    d_clear = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin n++; cycle(); end
    chk("b2b_wait_start", 16'(busy), 16'd1);
    while (clear_done !== 1'b1 && n < 40) begin n++; cycle(); end
    chk("b2b_first_done", 16'(clear_done), 16'd1);
    d_clear = 1'b1;
    cycle();
    d_clear = 1'b0;
    chk("b2b_restart", 16'(busy), 16'd1);
    n = 0;
    while (busy === 1'b1 && n < 20) begin n++; cycle(); end

    // Reset in the middle of a sweep.
    for (int k = 0; k < 8; k++) begin
      d_load = 1'b1; d_address = 3'(k); d_in = 16'hA5A0 + 16'(k);
      cycle();
    end
    idle_inputs();
    d_addr_a = 3'd6;
    d_clear = 1'b1;
    cycle();
    d_clear = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_out_a", out_a, '0);
    chk("mid_rst_done", 16'(clear_done), 16'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d_addr_a = 3'(k);
      cycle();
      chk("post_rst_zero", out_a, '0);
      chk("post_rst_no_done", 16'(clear_done), 16'd0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      d_load    = 1'($urandom_range(0, 1));
      d_address = 3'($urandom_range(0, 7));
      d_in      = 16'($urandom);
      d_addr_a  = 3'($urandom_range(0, 7));
      d_addr_b  = 3'($urandom_range(0, 7));
      d_clear   = ($urandom_range(0, 15) == 0);
      cycle();
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
